// File: rtl/pc_sequencer.sv
// Program counter sequencer with a req/done run handshake, absolute and relative jumps,
// a hardware call/return stack and a stall input. Every output comes straight from a register.
module pc_sequencer #(
  parameter int          D           = 12,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned START_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req,
  input  logic                               halt_i,
  input  logic                               stall,
  input  logic                               jump_en,
  input  logic                               jump_rel,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic [D-1:0]                       target,
  output logic [D-1:0]                       prog_ctr,
  output logic                               running,
  output logic                               done,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [D-1:0]  START_PC = D'(START_ADDR);
  localparam logic [DW-1:0] FULL     = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            push;
  logic [D-1:0]    push_data;
  logic [SW-1:0]   push_idx, top_idx;
  logic [D-1:0]    stack_q [STACK_DEPTH];

  // depth_q is the next free slot; the top entry sits one below it
  assign push_idx  = depth_q[SW-1:0];
  assign top_idx   = SW'(depth_q - DW'(1));
  assign push_data = pc_q + D'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      depth_q   <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = START_PC;
        if (req) begin
          state_d = S_RUN;
          depth_d = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (halt_i) begin
            state_d = S_DONE;
          end else if (ret_en) begin
            if (depth_q == '0) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              pc_d    = stack_q[top_idx];
              depth_d = depth_q - DW'(1);
            end
          end else if (call_en) begin
            if (depth_q == FULL) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              push    = 1'b1;
              pc_d    = target;
              depth_d = depth_q + DW'(1);
            end
          end else if (jump_en) begin
            pc_d = jump_rel ? (pc_q + target) : target;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
          pc_d    = START_PC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they register alongside it
  always_comb begin
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= push_data;
  end

  assign prog_ctr  = pc_q;
  assign running   = running_q;
  assign done      = done_q;
  assign stack_err = err_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based run model checked every negedge,
// plus literal expectations from the hand-worked scenarios.
module tb_pc_sequencer;
  localparam int D = 12;
  localparam int SD = 4;
  localparam int START = 0;
  localparam int MASK = (1 << D) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0, halt_i = 1'b0, stall = 1'b0;
  logic          jump_en = 1'b0, jump_rel = 1'b0, call_en = 1'b0, ret_en = 1'b0;
  logic [D-1:0]  target = '0;
  logic [D-1:0]  prog_ctr;
  logic          running, done, stack_err;
  logic [2:0]    depth;

  pc_sequencer #(.D(D), .STACK_DEPTH(SD), .START_ADDR(START)) dut (
    .clk(clk), .reset(reset), .req(req), .halt_i(halt_i), .stall(stall),
    .jump_en(jump_en), .jump_rel(jump_rel), .call_en(call_en), .ret_en(ret_en),
    .target(target), .prog_ctr(prog_ctr), .running(running), .done(done),
    .stack_err(stack_err), .depth(depth)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  // Model: a run is either idle, running or done; the stack is a plain queue
  int m_pc = START;
  bit m_run = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int stk[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = START; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
    stk.delete();
  endtask

  task automatic model_update();
    if (m_run) begin
      if (!stall) begin
        if (halt_i) begin
          m_run = 1'b0; m_done = 1'b1;
        end else if (ret_en) begin
          if (stk.size() == 0) begin
            m_err = 1'b1; m_run = 1'b0; m_done = 1'b1;
          end else m_pc = stk.pop_back();
        end else if (call_en) begin
          if (stk.size() == SD) begin
            m_err = 1'b1; m_run = 1'b0; m_done = 1'b1;
          end else begin
            stk.push_back((m_pc + 1) & MASK);
            m_pc = int'(target);
          end
        end else if (jump_en) begin
          m_pc = jump_rel ? ((m_pc + int'(target)) & MASK) : int'(target);
        end else m_pc = (m_pc + 1) & MASK;
      end
    end else if (m_done) begin
      if (!req) begin
        m_done = 1'b0; m_pc = START;
      end
    end else begin
      if (req) begin
        m_run = 1'b1; m_err = 1'b0; stk.delete();
      end
      m_pc = START;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    $display("t=%0t req=%0b halt=%0b stall=%0b jmp=%0b rel=%0b call=%0b ret=%0b tgt=%03h -> pc=%03h run=%0b done=%0b err=%0b depth=%0d",
             $time, req, halt_i, stall, jump_en, jump_rel, call_en, ret_en, target,
             prog_ctr, running, done, stack_err, depth);
  endtask

  task automatic clr();
    halt_i = 0; stall = 0; jump_en = 0; jump_rel = 0; call_en = 0; ret_en = 0; target = '0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", int'(prog_ctr), m_pc);
      chk("running", int'(running), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("stack_err", int'(stack_err), int'(m_err));
      chk("depth", int'(depth), stk.size());
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_pc", int'(prog_ctr), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_depth", int'(depth), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cmp_en = 1'b1;

    // 1: plain sequencing then halt
    req = 1; step();
    chk("t1_pc0", int'(prog_ctr), 0);
    chk("t1_run", int'(running), 1);
    step(); chk("t1_pc1", int'(prog_ctr), 1);
    step(); step(); chk("t1_pc3", int'(prog_ctr), 3);
    halt_i = 1; step(); halt_i = 0;
    chk("t1_done", int'(done), 1);
    chk("t1_pc_frozen", int'(prog_ctr), 3);
    step(); chk("t1_pc_hold", int'(prog_ctr), 3);
    req = 0; step();
    chk("t1_idle_done", int'(done), 0);

    // 2: relative and absolute jumps
    req = 1; step();
    for (int i = 0; i < 5; i++) step();
    chk("t2_pc5", int'(prog_ctr), 5);
    jump_en = 1; jump_rel = 1; target = 12'hFFE; step();
    chk("t2_rel", int'(prog_ctr), 3);
    jump_rel = 0; target = 12'h0A0; step();
    chk("t2_abs", int'(prog_ctr), 'h0A0);
    chk("t2_model", m_pc, 'h0A0);

    // 3: nested calls and returns
    target = 12'd10; step(); clr();
    call_en = 1; target = 12'd20; step();
    chk("t3_pc20", int'(prog_ctr), 20); chk("t3_d1", int'(depth), 1);
    target = 12'd40; step();
    chk("t3_pc40", int'(prog_ctr), 40); chk("t3_d2", int'(depth), 2);
    clr(); ret_en = 1; step();
    chk("t3_pc21", int'(prog_ctr), 21); chk("t3_d1b", int'(depth), 1);
    step();
    chk("t3_pc11", int'(prog_ctr), 11); chk("t3_d0", int'(depth), 0);
    clr();

    // 4: overflow on the fifth call, then underflow on a fresh run
    call_en = 1; target = 12'h100;
    for (int i = 0; i < 5; i++) step();
    clr();
    chk("t4_err", int'(stack_err), 1);
    chk("t4_done", int'(done), 1);
    chk("t4_depth", int'(depth), 4);
    req = 0; step();
    chk("t4_err_held", int'(stack_err), 1);
    req = 1; step();
    chk("t4_err_clr", int'(stack_err), 0);
    ret_en = 1; step(); clr();
    chk("t4_uflow", int'(stack_err), 1);
    chk("t4_uflow_done", int'(done), 1);

    // 5: stall blocks a pending call
    req = 0; step();
    req = 1; step();
    stall = 1; call_en = 1; target = 12'h055;
    for (int i = 0; i < 3; i++) step();
    chk("t5_pc_stall", int'(prog_ctr), 0);
    chk("t5_d_stall", int'(depth), 0);
    stall = 0; step(); clr();
    chk("t5_call", int'(prog_ctr), 'h055);
    chk("t5_depth", int'(depth), 1);

    // 6: wrap, req drop mid-run, async reset, clean restart
    jump_en = 1; target = 12'hFFF; step(); clr();
    req = 0; step();
    chk("t6_wrap", int'(prog_ctr), 0);
    chk("t6_still_run", int'(running), 1);
    step(); step();
    reset = 0; #1; model_reset();
    chk("t6_rst_pc", int'(prog_ctr), START);
    chk("t6_rst_run", int'(running), 0);
    chk("t6_rst_depth", int'(depth), 0);
    @(posedge clk); #1;
    reset = 1;
    req = 1; step();
    chk("t6_restart", int'(running), 1);
    step(); chk("t6_pc1", int'(prog_ctr), 1);
    @(negedge clk); #1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
